// File: rtl/affine_interp_pkg.sv
// Shared constants for the affine 6-tap quarter-phase interpolation path.
package affine_interp_pkg;

    localparam int SHIFT     = 6;
    localparam int ROUND_OFS = 32;
    localparam int NUM_TAPS  = 6;
    localparam int NUM_PH    = 4;

    typedef enum logic [1:0] {FRAC_0, FRAC_Q, FRAC_H, FRAC_3Q} frac_e;

    // [phase][tap]; every row sums to 64
    localparam int COEF [NUM_PH][NUM_TAPS] = '{
        '{0,   0, 64,  0,   0, 0},
        '{2,  -9, 57, 18,  -4, 0},
        '{3, -11, 40, 40, -11, 3},
        '{0,  -4, 18, 57,  -9, 2}
    };

endpackage

// File: rtl/affine_tap_mcm.sv
// One filter tap: all four phase products of a sample, built from shifts and adds.
module affine_tap_mcm
    import affine_interp_pkg::*;
#(
    parameter int BD    = 10,
    parameter int ACC_W = BD + 9,
    parameter int TAP   = 0
) (
    input  logic [BD-1:0]                   x,
    output logic [NUM_PH-1:0][ACC_W-1:0]    prod
);

    // Constant coefficients are elaboration-time, so the loop folds into a fixed adder tree.
    function automatic logic [ACC_W-1:0] cmul(input logic [BD-1:0] v, input int c);
        logic [ACC_W-1:0] xe;
        logic [ACC_W-1:0] acc;
        int               m;
        xe  = ACC_W'(v);
        acc = '0;
        m   = (c < 0) ? -c : c;
        for (int b = 0; b < 8; b++)
            if (m[b]) acc = acc + (xe << b);
        return (c < 0) ? -acc : acc;
    endfunction

    for (genvar f = 0; f < NUM_PH; f++) begin : g_ph
        assign prod[f] = cmul(x, COEF[f][TAP]);
    end

endmodule

// File: rtl/affine_interp_filter.sv
// Streaming 6-tap horizontal quarter-phase interpolator: window, MCM taps, sum/round/clip.
module affine_interp_filter
    import affine_interp_pkg::*;
#(
    parameter int BD    = 10,
    parameter int SHIFT = 6,
    parameter int ACC_W = BD + 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BD-1:0] in_sample,
    input  logic [1:0]    in_frac,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BD-1:0] out_sample,
    output logic          out_last
);

    localparam int STAGES = 2;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << BD) - 1);

    logic                                      stall, accept, launch;
    logic [2:0]                                count;
    logic [NUM_TAPS-1:0][BD-1:0]               win, win_nxt;
    logic [NUM_TAPS-1:0][NUM_PH-1:0][ACC_W-1:0] tap_prod;
    logic [NUM_TAPS-1:0][ACC_W-1:0]            sel;
    frac_e                                     ph;
    logic [STAGES:1]                           vld_pipe, last_pipe;
    logic signed [ACC_W-1:0]                   p0, p1, total, rnd;
    logic [BD-1:0]                             clip;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign launch   = accept && (count >= 3'(NUM_TAPS - 1));

    // Taps see the window as it will be after this beat, so launch uses the new sample.
    assign win_nxt = {in_sample, win[NUM_TAPS-1:1]};
    assign ph      = frac_e'(in_frac);

    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
        affine_tap_mcm #(.BD(BD), .ACC_W(ACC_W), .TAP(t)) u_mcm (
            .x    (win_nxt[t]),
            .prod (tap_prod[t])
        );
        assign sel[t] = tap_prod[t][ph];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win   <= '0;
            count <= '0;
        end else if (accept) begin
            win <= win_nxt;
            if (in_last)
                count <= '0;
            else if (count != 3'(NUM_TAPS))
                count <= count + 3'd1;
        end
    end

    assign total = p0 + p1;
    assign rnd   = (total + ACC_W'(ROUND_OFS)) >>> SHIFT;

    always_comb begin
        clip = rnd[BD-1:0];
        if (rnd < 0)         clip = '0;
        else if (rnd > MAXV) clip = '1;
    end

    // S1 keeps the two partial sums; S2 is the output register. Both freeze on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            last_pipe  <= '0;
            p0         <= '0;
            p1         <= '0;
            out_sample <= '0;
        end else if (!stall) begin
            vld_pipe  <= {vld_pipe[1], launch};
            last_pipe <= {last_pipe[1], launch && in_last};
            if (launch) begin
                p0 <= $signed(sel[0]) + $signed(sel[1]) + $signed(sel[2]);
                p1 <= $signed(sel[3]) + $signed(sel[4]) + $signed(sel[5]);
            end
            if (vld_pipe[1])
                out_sample <= clip;
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_last  = last_pipe[STAGES];

endmodule
